// File: rtl/handshake_tx_fifo.sv
// FIFO-buffered req/ack transmitter with synchronised ack, 4- or 2-phase.
// Optional ack-wait timeout flag built when HSK_TX_TIMEOUT_EN is defined.
module handshake_tx_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TWO_PHASE      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          iTxClk,
  input  logic                          iRstTx,
  input  logic                          iDataValid,
  input  logic [DATA_WIDTH-1:0]         iData,
  output logic                          oDataRdy,
  input  logic                          iRxAck,
  output logic                          oTxRdy,
  output logic [DATA_WIDTH-1:0]         oTxData,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoLevel,
  output logic                          oTimeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    tx_rdy_q, tx_rdy_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic ack_s;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign ack_s    = ack_sync_q[SYNC_STAGES-1];
  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = iDataValid && !full;
  assign oDataRdy = !full;

  assign oTxRdy     = tx_rdy_q;
  assign oTxData    = tx_data_q;
  assign oFifoLevel = level_q;

  // State register
  always_ff @(posedge iTxClk) begin
    if (iRstTx) begin
      state_q   <= IDLE;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_rdy_q  <= tx_rdy_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Next state; completion falls straight through to the next pop
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (TWO_PHASE != 0) begin
          if (ack_s == tx_rdy_q) begin
            pop     = !empty;
            state_d = empty ? IDLE : REQ;
          end
        end else if (ack_s) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          pop     = !empty;
          state_d = empty ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx_rdy_d  = tx_rdy_q;
    tx_data_d = tx_data_q;
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
      tx_rdy_d  = (TWO_PHASE != 0) ? !tx_rdy_q : 1'b1;
    end else if ((TWO_PHASE == 0) && (state_q == REQ) && ack_s) begin
      tx_rdy_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], iRxAck};
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge iTxClk) begin
    if (iRstTx) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ack_sync_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  // Storage has no reset; level gates every read
  always_ff @(posedge iTxClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= iData;
    end
  end

`ifdef HSK_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  logic          wait_entry;

  assign wait_entry = (state_d != IDLE) &&
                      ((state_d != state_q) || pop);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (wait_entry) begin
      to_cnt_d = '0;
    end else if ((state_q != IDLE) &&
                 (to_cnt_q != TW'(TIMEOUT_CYCLES))) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    timeout_d = timeout_q ||
                (to_cnt_d == TW'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge iTxClk) begin
    if (iRstTx) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign oTimeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_tx_fifo.sv
// Bench for handshake_tx_fifo: 4-phase and 2-phase instances against a
// queue-level model, plus directed literal checks.
module tb_handshake_tx_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int TOC   = 16;
`ifdef HSK_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld  [2];
  logic [DW-1:0] dat  [2];
  logic          ack  [2];
  logic          drdy [2];
  logic          trdy [2];
  logic [DW-1:0] tdat [2];
  logic [2:0]    lvl  [2];
  logic          tout [2];

  always #5 clk = ~clk;

  handshake_tx_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS),
    .TWO_PHASE(0), .TIMEOUT_CYCLES(TOC)
  ) u4 (
    .iTxClk(clk), .iRstTx(rst), .iDataValid(vld[0]), .iData(dat[0]),
    .oDataRdy(drdy[0]), .iRxAck(ack[0]), .oTxRdy(trdy[0]),
    .oTxData(tdat[0]), .oFifoLevel(lvl[0]), .oTimeout(tout[0])
  );

  handshake_tx_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS),
    .TWO_PHASE(1), .TIMEOUT_CYCLES(TOC)
  ) u2 (
    .iTxClk(clk), .iRstTx(rst), .iDataValid(vld[1]), .iData(dat[1]),
    .oDataRdy(drdy[1]), .iRxAck(ack[1]), .oTxRdy(trdy[1]),
    .oTxData(tdat[1]), .oFifoLevel(lvl[1]), .oTimeout(tout[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word list plus handshake status, ack seen SS edges late
  logic [DW-1:0] mbuf  [2][64];
  int            mhd   [2];
  int            mcnt  [2];
  logic          mrdy  [2];
  logic          mbusy [2];
  logic          mrel  [2];
  logic [DW-1:0] mdat  [2];
  logic [7:0]    ahist [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int   hd  = mhd[i];
      automatic int   cnt = mcnt[i];
      automatic int   pre = mcnt[i];
      automatic logic r   = mrdy[i];
      automatic logic b   = mbusy[i];
      automatic logic rl  = mrel[i];
      automatic logic a   = ahist[i][SS-1];
      automatic logic p   = 1'b0;
      if (rst) begin
        mhd[i] <= 0; mcnt[i] <= 0; mrdy[i] <= 1'b0;
        mbusy[i] <= 1'b0; mrel[i] <= 1'b0; mdat[i] <= '0;
        ahist[i] <= '0;
      end else begin
        if (i == 0) begin
          if (r) begin
            if (a) begin r = 1'b0; rl = 1'b1; end
          end else if (!(rl && a)) begin
            rl = 1'b0;
            if (pre > 0) begin p = 1'b1; r = 1'b1; end
          end
        end else begin
          if (b && (a == r)) b = 1'b0;
          if (!b && pre > 0) begin p = 1'b1; r = !r; b = 1'b1; end
        end
        if (p) begin
          mdat[i] <= mbuf[i][hd % 64];
          hd++; cnt--;
        end
        if (vld[i] && pre < DEPTH) begin
          mbuf[i][(hd + cnt) % 64] <= dat[i];
          cnt++;
        end
        mhd[i] <= hd; mcnt[i] <= cnt; mrdy[i] <= r;
        mbusy[i] <= b; mrel[i] <= rl;
        ahist[i] <= {ahist[i][6:0], ack[i]};
      end
    end
  end

  string nm [2] = '{"4ph", "2ph"};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk({nm[i], ".level"},   32'(lvl[i]),  32'(mcnt[i]));
      chk({nm[i], ".data_rdy"}, 32'(drdy[i]), 32'(mcnt[i] < DEPTH));
      chk({nm[i], ".tx_rdy"},  32'(trdy[i]), 32'(mrdy[i]));
      chk({nm[i], ".tx_data"}, tdat[i],      mdat[i]);
`ifndef HSK_TX_TIMEOUT_EN
      chk({nm[i], ".timeout"}, 32'(tout[i]), 32'd0);
`endif
    end
  end

  // Receiver: mirror oTxRdy onto ack three cycles later when enabled
  bit   resp_en [2];
  logic man_ack [2];
  int   dly     [2];
  int   tog2 = 0;
  int   r4   = 0;
  logic prev2 = 1'b0;
  logic prev4 = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ack[i] <= 1'b0; dly[i] <= 0;
      end else if (resp_en[i]) begin
        if (trdy[i] != ack[i]) begin
          if (dly[i] == 2) begin ack[i] <= trdy[i]; dly[i] <= 0; end
          else dly[i] <= dly[i] + 1;
        end else begin
          dly[i] <= 0;
        end
      end else begin
        ack[i] <= man_ack[i]; dly[i] <= 0;
      end
    end
    prev2 <= trdy[1];
    prev4 <= trdy[0];
    if (rst) tog2 <= 0;
    else if (trdy[1] !== prev2) tog2 <= tog2 + 1;
    if (!rst && trdy[0] && !prev4) r4 <= r4 + 1;
  end

  task automatic drain(int i);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (lvl[i] == 0 && trdy[i] == ack[i] && (i == 1 || !trdy[i])) break;
    end
    chk("drain_bound", 32'(k < 400), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic burst(int i, logic [DW-1:0] base, int n);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      vld[i] = 1'b1; dat[i] = base + DW'(k);
      @(negedge clk);
    end
    vld[i] = 1'b0;
  endtask

  initial begin
    int e;
    int rb;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; dat[i] = '0; man_ack[i] = 1'b0; resp_en[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst.tx_rdy",   32'(trdy[0]), 32'd0);
    chk("rst.tx_data",  tdat[0],      32'd0);
    chk("rst.level",    32'(lvl[0]),  32'd0);
    chk("rst.data_rdy", 32'(drdy[0]), 32'd1);
    chk("rst.timeout",  32'(tout[0]), 32'd0);

    // Single word, 4-phase
    resp_en[0] = 1'b1;
    @(negedge clk) vld[0] = 1'b1; dat[0] = 32'hA5A5_0001;
    @(negedge clk) vld[0] = 1'b0;
    chk("t1.level_after_push", 32'(lvl[0]), 32'd1);
    chk("t1.rdy_after_push",   32'(trdy[0]), 32'd0);
    @(posedge clk); #1;
    chk("t1.rdy_rise",  32'(trdy[0]), 32'd1);
    chk("t1.tx_data",   tdat[0], 32'hA5A5_0001);
    chk("t1.level_pop", 32'(lvl[0]), 32'd0);
    for (e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (ack[0]) break;
    end
    chk("t1.ack_seen", 32'(ack[0]), 32'd1);
    e = 1;
    while (trdy[0] && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    chk("t1.ack_to_fall_edges", 32'(e), 32'd3);
    drain(0);
    chk("t1.final_level", 32'(lvl[0]), 32'd0);
    chk("t1.data_held",   tdat[0], 32'hA5A5_0001);

    // Burst to full with the receiver stalled
    resp_en[0] = 1'b0; man_ack[0] = 1'b0;
    rb = r4;
    burst(0, 32'hB000_0000, 6);
    chk("t2.level_full", 32'(lvl[0]),  32'd4);
    chk("t2.not_ready",  32'(drdy[0]), 32'd0);
    chk("t2.in_flight",  tdat[0], 32'hB000_0000);
    resp_en[0] = 1'b1;
    drain(0);
    chk("t2.delivered", 32'(r4 - rb), 32'd5);
    chk("t2.last_word", tdat[0], 32'hB000_0004);

    // Push on the same edge as a pop at level 2
    resp_en[0] = 1'b0; man_ack[0] = 1'b0;
    burst(0, 32'hC000_0000, 3);
    repeat (2) @(negedge clk);
    chk("t3.level2", 32'(lvl[0]), 32'd2);
    @(posedge clk) man_ack[0] = 1'b1;
    for (e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (!trdy[0]) break;
    end
    chk("t3.rdy_fell", 32'(trdy[0]), 32'd0);
    @(posedge clk) man_ack[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) vld[0] = 1'b1; dat[0] = 32'hC000_0003;
    @(posedge clk); #1;
    chk("t3.level_kept", 32'(lvl[0]), 32'd2);
    chk("t3.rereq",      32'(trdy[0]), 32'd1);
    chk("t3.next_word",  tdat[0], 32'hC000_0001);
    @(negedge clk) vld[0] = 1'b0;
    resp_en[0] = 1'b1;
    drain(0);
    chk("t3.last_word", tdat[0], 32'hC000_0003);

    // Two-phase, three words
    resp_en[1] = 1'b1;
    burst(1, 32'hD000_0000, 3);
    drain(1);
    chk("t4.toggles",   32'(tog2), 32'd3);
    chk("t4.rdy_level", 32'(trdy[1]), 32'd1);
    chk("t4.last_word", tdat[1], 32'hD000_0002);

    // Reset mid-handshake
    resp_en[0] = 1'b0; man_ack[0] = 1'b0;
    burst(0, 32'hE000_0000, 4);
    chk("t5.level3", 32'(lvl[0]), 32'd3);
    chk("t5.in_req", 32'(trdy[0]), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("t5.rdy",   32'(trdy[0]), 32'd0);
    chk("t5.level", 32'(lvl[0]),  32'd0);
    chk("t5.data",  tdat[0],      32'd0);
    @(negedge clk) rst = 1'b0;

    // Ack never arrives
    burst(0, 32'hF000_0000, 1);
    repeat (5) @(negedge clk);
    chk("t6.no_early_timeout", 32'(tout[0]), 32'd0);
    repeat (40) @(negedge clk);
    chk("t6.timeout", 32'(tout[0]), 32'(TO_EN));
    resp_en[0] = 1'b1;
    drain(0);
    chk("t6.sticky",  32'(tout[0]), 32'(TO_EN));
    chk("t6.drained", 32'(lvl[0]),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
